board_ram_writer: RTL and testbench
===================================

Name: board_ram_writer

Overview:
- Write-side controller for the 64-cell, 2-bit-per-cell board RAM that the LED matrix scanner reads.
- Accepts place, remove and clear commands from game logic over a valid/ready handshake.
- For place and remove, reads the target cell and checks it before writing. Clear sweeps every address.
- Maintains per-side stone counts. Cell encoding {red,green}: 2'b00 empty, 2'b10 red, 2'b01 green, 2'b11 corrupt.

Parameters:
- CLEAR_ON_RESET, 1, when 1 a full clear sweep runs automatically after reset release, before any command is accepted.
- CELLS, 64, number of board cells. Fixed 8x8; addresses 0..63 = {row[2:0], col[2:0]}.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_op  in  2  00 place, 01 remove, 10 clear, 11 reserved
- cmd_pos  in  6  target cell {row,col}; ignored for clear
- cmd_color  in  1  stone side; `SIDE_RED` means red, otherwise green
- resp_valid  out  1  one-cycle completion pulse
- resp_code  out  2  00 OK, 01 OCCUPIED, 10 MISMATCH, 11 BAD_OP; valid only with resp_valid
- ram_rd_addr  out  6  RAM check-port address
- ram_rd_data  in  2  RAM data; synchronous, 1-cycle latency after address
- ram_wr_en  out  1  RAM write strobe
- ram_wr_addr  out  6  RAM write address
- ram_wr_data  out  2  RAM write data
- red_count  out  7  red stones on board, 0..64
- green_count  out  7  green stones on board, 0..64
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - cmd_ready=0 during reset; cmd_ready=1 in IDLE.
  - resp_valid=0, resp_code=00, ram_wr_en=0, all addresses and data 0.
  - Counts=0, busy=1 if CLEAR_ON_RESET else 0.
- Reset mid-operation: abort immediately; no further writes. RAM contents are undefined unless the auto-clear runs.
- States: IDLE, RD, CHK, WR, CLEAR, ERR.
- Command capture: cmd_valid && cmd_ready at edge T latches op, pos and color. Inputs are don't-care afterwards.
- Transitions from IDLE: op 00/01 -> RD; op 10 -> CLEAR (address counter = 0); op 11 -> ERR.
- RD (cycle T+1): ram_rd_addr = latched pos. Next state CHK.
- CHK (cycle T+2): ram_rd_data is valid.
  - Place: data==00 -> WR; otherwise resp_valid=1, code=01, -> IDLE. Corrupt 11 counts as occupied.
  - Remove: data equals the stone of the latched color -> WR; otherwise resp_valid=1, code=10, -> IDLE.
- WR (cycle T+3): single write, resp_valid=1, code=00, -> IDLE.
  - ram_wr_en=1, ram_wr_addr=pos.
  - Write data: place writes the color stone; remove writes 00.
  - Count update on the same edge: place increments the side count; remove decrements it.
- Latencies: success response at T+3; rejection at T+2; BAD_OP (ERR, no RAM access) at T+1.
- CLEAR:
  - ram_wr_en=1, ram_wr_data=00, ram_wr_addr = counter 0..63, one address per cycle, 64 cycles.
  - On address 63: both counts <=0, resp_valid=1 with code 00, -> IDLE.
  - Wrap from 63 is never performed; the counter stops.
  - An auto-clear after reset also pulses resp_valid. Upstream ignores it because no command is outstanding.
- Write timing: exactly one RAM write per successful place or remove. No RAM write ever occurs in IDLE, RD, CHK or ERR.
- Handshake: cmd_ready=0 from the accept edge until the cycle after resp_valid (back in IDLE). A new command is accepted at the earliest on the cycle following resp_valid.
- Counts cannot overflow or underflow: writes are gated by the occupancy check and the board has 64 cells.
- ram_rd_addr holds its last value outside RD. The scanner's read port is independent; no arbitration is needed.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> 64 consecutive writes of 00 to addresses 0..63, cmd_ready low throughout; resp_valid with code 00 on the 64th write cycle; then IDLE with cmd_ready=1 and both counts 0.
- Place red at pos 6'd27 on an empty cell -> RD addr 27 at T+1; write addr 27, data 2'b10 at T+3 with resp code 00; red_count 0->1.
- Place green at 27 again (cell holds 2'b10) -> resp_valid at T+2 with code 01; no write; counts unchanged.
- Remove green at 27 (cell holds red) -> code 10, no write. Remove red at 27 -> write 00 at T+3, code 00, red_count 1->0.
- cmd_op=11 -> resp_valid at T+1 with code 11; no RAM read or write.
- Reset asserted during CLEAR at address 30 -> ram_wr_en drops asynchronously; after release, a new sweep restarts at address 0.

Source files
------------

// File: rtl/board_ram_writer.sv
// Write-side controller for the 8x8 LED board RAM (2 bits per cell).
// Handles place/remove/clear commands over a valid/ready handshake.
// Place/remove do a read-check-write; clear sweeps every cell to empty.
// It also keeps running red/green stone counts for the game logic.
module board_ram_writer #(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int CELLS          = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_pos,
  input  logic       cmd_color,
  output logic       resp_valid,
  output logic [1:0] resp_code,
  output logic [5:0] ram_rd_addr,
  input  logic [1:0] ram_rd_data,
  output logic       ram_wr_en,
  output logic [5:0] ram_wr_addr,
  output logic [1:0] ram_wr_data,
  output logic [6:0] red_count,
  output logic [6:0] green_count,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CHK, S_WR, S_CLEAR, S_ERR
  } state_e;

  localparam logic [1:0] OP_PLACE  = 2'b00;
  localparam logic [1:0] OP_REMOVE = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  localparam logic [1:0] RC_OK       = 2'b00;
  localparam logic [1:0] RC_OCCUPIED = 2'b01;
  localparam logic [1:0] RC_MISMATCH = 2'b10;
  localparam logic [1:0] RC_BAD_OP   = 2'b11;

  // Cell encoding is {red, green}.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_RED   = 2'b10;
  localparam logic [1:0] ST_GREEN = 2'b01;

  localparam logic       SIDE_RED  = 1'b1;
  localparam logic [5:0] LAST_ADDR = 6'(CELLS - 1);

  state_e     state_q;
  logic [1:0] op_q;
  logic [5:0] pos_q;
  logic       color_q;
  logic [5:0] clr_cnt_q;
  logic       clr_done_q;
  logic       cmd_ready_q;
  logic       busy_q;
  logic       resp_valid_q;
  logic [1:0] resp_code_q;
  logic [5:0] rd_addr_q;
  logic       wr_en_q;
  logic [5:0] wr_addr_q;
  logic [1:0] wr_data_q;
  logic [6:0] red_q;
  logic [6:0] green_q;

  logic [1:0] side_stone;
  logic       chk_pass;

  // Stone pattern for the latched side and the occupancy check on read data.
  always_comb begin
    side_stone = (color_q == SIDE_RED) ? ST_RED : ST_GREEN;
    chk_pass   = 1'b0;
    if (op_q == OP_PLACE) chk_pass = (ram_rd_data == ST_EMPTY);
    else                  chk_pass = (ram_rd_data == side_stone);
  end

  // Main controller FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      op_q         <= 2'b00;
      pos_q        <= 6'd0;
      color_q      <= 1'b0;
      clr_cnt_q    <= 6'd0;
      clr_done_q   <= 1'b0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= CLEAR_ON_RESET;
      resp_valid_q <= 1'b0;
      resp_code_q  <= RC_OK;
      rd_addr_q    <= 6'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 6'd0;
      wr_data_q    <= 2'b00;
      red_q        <= 7'd0;
      green_q      <= 7'd0;
    end else begin
      // Response is a single-cycle pulse unless a state re-asserts it.
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_op;
            pos_q       <= cmd_pos;
            color_q     <= cmd_color;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            case (cmd_op)
              OP_PLACE, OP_REMOVE: begin
                state_q   <= S_RD;
                rd_addr_q <= cmd_pos;
              end
              OP_CLEAR: begin
                state_q    <= S_CLEAR;
                clr_cnt_q  <= 6'd0;
                clr_done_q <= 1'b0;
              end
              default: state_q <= S_ERR;
            endcase
          end else begin
            // Ready rises one cycle after the response pulse.
            cmd_ready_q <= 1'b1;
          end
        end
        S_RD: state_q <= S_CHK;
        S_CHK: begin
          if (chk_pass) begin
            state_q   <= S_WR;
            wr_en_q   <= 1'b1;
            wr_addr_q <= pos_q;
            wr_data_q <= (op_q == OP_PLACE) ? side_stone : ST_EMPTY;
          end else begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_code_q  <= (op_q == OP_PLACE) ? RC_OCCUPIED : RC_MISMATCH;
          end
        end
        S_WR: begin
          // Count moves on the same edge the RAM commits the write.
          wr_en_q      <= 1'b0;
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_code_q  <= RC_OK;
          if (op_q == OP_PLACE) begin
            if (color_q == SIDE_RED) red_q   <= red_q + 7'd1;
            else                     green_q <= green_q + 7'd1;
          end else begin
            if (color_q == SIDE_RED) red_q   <= red_q - 7'd1;
            else                     green_q <= green_q - 7'd1;
          end
        end
        S_CLEAR: begin
          if (!clr_done_q) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= clr_cnt_q;
            wr_data_q <= ST_EMPTY;
            if (clr_cnt_q == LAST_ADDR) begin
              // Last write of the sweep carries the response; counter parks.
              clr_done_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              resp_code_q  <= RC_OK;
              red_q        <= 7'd0;
              green_q      <= 7'd0;
            end else begin
              clr_cnt_q <= clr_cnt_q + 6'd1;
            end
          end else begin
            wr_en_q     <= 1'b0;
            clr_done_q  <= 1'b0;
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        S_ERR: begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_code_q  <= RC_BAD_OP;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign resp_valid  = resp_valid_q;
  assign resp_code   = resp_code_q;
  assign ram_rd_addr = rd_addr_q;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign red_count   = red_q;
  assign green_count = green_q;

endmodule

// File: tb/tb_board_ram_writer.sv
// Directed bench for board_ram_writer with a synchronous RAM model and
// response/write scoreboards keyed on expected cycle.
module tb_board_ram_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_pos;
  logic       cmd_color;
  logic       resp_valid;
  logic [1:0] resp_code;
  logic [5:0] ram_rd_addr;
  logic [1:0] ram_rd_data;
  logic       ram_wr_en;
  logic [5:0] ram_wr_addr;
  logic [1:0] ram_wr_data;
  logic [6:0] red_count;
  logic [6:0] green_count;
  logic       busy;

  board_ram_writer #(.CLEAR_ON_RESET(1'b1), .CELLS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_pos(cmd_pos), .cmd_color(cmd_color),
    .resp_valid(resp_valid), .resp_code(resp_code),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .red_count(red_count), .green_count(green_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Board RAM: synchronous read, one cycle latency.
  logic [1:0] mem [64];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  typedef struct { logic [1:0] code; int cyc; } rsp_t;
  typedef struct { logic [5:0] addr; logic [1:0] data; int cyc; } wr_t;
  rsp_t rq[$];
  wr_t  wq[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] shadow [64];
  int exp_red = 0;
  int exp_green = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every write and response must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_wr_en) begin
        wr_t w;
        chk("wr_ready_low", cmd_ready, 0);
        chk("wr_expected", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("wr_addr", ram_wr_addr, w.addr);
          chk("wr_data", ram_wr_data, w.data);
          chk("wr_cycle", cyc, w.cyc);
        end
      end
      if (resp_valid) begin
        rsp_t r;
        chk("rsp_ready_low", cmd_ready, 0);
        chk("rsp_expected", rq.size() > 0, 1);
        if (rq.size() > 0) begin
          r = rq.pop_front();
          chk("rsp_code", resp_code, r.code);
          chk("rsp_cycle", cyc, r.cyc);
        end
      end
    end
  end

  task automatic push_sweep(input int first);
    for (int k = 0; k < 64; k++) wq.push_back('{6'(k), 2'b00, first + k});
    rq.push_back('{2'b00, first + 63});
    for (int k = 0; k < 64; k++) shadow[k] = 2'b00;
    exp_red = 0;
    exp_green = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (wq.size() == 0 && rq.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", (wq.size() == 0 && rq.size() == 0), 1);
  endtask

  // Wait for ready, present one command for one cycle, load expectations.
  task automatic issue(input logic [1:0] op, input logic [5:0] pos, input logic color);
    int t;
    logic [1:0] stone;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready === 1'b1) break;
      @(negedge clk);
    end
    chk("ready_timeout", cmd_ready, 1);
    t = cyc + 1;
    stone = color ? 2'b10 : 2'b01;
    cmd_valid = 1'b1; cmd_op = op; cmd_pos = pos; cmd_color = color;
    case (op)
      2'b00: if (shadow[pos] == 2'b00) begin
        wq.push_back('{pos, stone, t + 2});
        rq.push_back('{2'b00, t + 3});
        shadow[pos] = stone;
        if (color) exp_red++; else exp_green++;
      end else rq.push_back('{2'b01, t + 2});
      2'b01: if (shadow[pos] == stone) begin
        wq.push_back('{pos, 2'b00, t + 2});
        rq.push_back('{2'b00, t + 3});
        shadow[pos] = 2'b00;
        if (color) exp_red--; else exp_green--;
      end else rq.push_back('{2'b10, t + 2});
      2'b10: push_sweep(t + 1);
      default: rq.push_back('{2'b11, t + 1});
    endcase
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_pos = 6'($urandom);
    cmd_color = 1'($urandom);
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] pos, input logic color);
    logic [5:0] pos_v;
    pos_v = pos;
    issue(op, pos, color);
    chk("busy_after_accept", busy, 1);
    if (op[1] == 1'b0) chk("rd_addr", ram_rd_addr, pos_v);
    drain();
    chk("red_count", red_count, 7'(exp_red));
    chk("green_count", green_count, 7'(exp_green));
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_pos = 6'd0; cmd_color = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_code", resp_code, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_rd_addr", ram_rd_addr, 0);
    chk("rst_red", red_count, 0);
    chk("rst_green", green_count, 0);
    chk("rst_busy", busy, 1);

    // Auto-clear sweep after reset release.
    push_sweep(cyc + 1);
    rst_n = 1'b1;
    drain();
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_red", red_count, 0);
    chk("idle_green", green_count, 0);

    send(2'b00, 6'd27, 1'b1);   // place red on empty -> OK
    send(2'b00, 6'd27, 1'b0);   // place green on red -> OCCUPIED
    send(2'b01, 6'd27, 1'b0);   // remove green from red -> MISMATCH
    send(2'b01, 6'd27, 1'b1);   // remove red -> OK
    send(2'b11, 6'd12, 1'b1);   // reserved op -> BAD_OP
    send(2'b00, 6'd0,  1'b0);   // corner cells
    send(2'b00, 6'd63, 1'b0);
    send(2'b00, 6'd63, 1'b1);   // occupied by green
    send(2'b01, 6'd5,  1'b0);   // remove from empty -> MISMATCH
    send(2'b00, 6'd9,  1'b1);

    // Corrupt cell counts as occupied and matches neither side.
    mem[40] = 2'b11;
    shadow[40] = 2'b11;
    send(2'b00, 6'd40, 1'b1);
    send(2'b01, 6'd40, 1'b1);

    // Commanded clear wipes the board and both counts.
    send(2'b10, 6'd17, 1'b0);
    send(2'b00, 6'd40, 1'b0);

    // Reset in the middle of a clear sweep.
    issue(2'b10, 6'd0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (ram_wr_en === 1'b1 && ram_wr_addr == 6'd30) break;
      @(negedge clk);
    end
    chk("clr_reach_30", ram_wr_addr, 30);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", ram_wr_en, 0);
    chk("midrst_ready", cmd_ready, 0);
    chk("midrst_green", green_count, 0);
    wq.delete();
    rq.delete();
    @(negedge clk);
    push_sweep(cyc + 1);
    rst_n = 1'b1;
    drain();
    send(2'b00, 6'd27, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
